sme_rng_feeder: RTL and testbench

Randomness-supply stage that sits directly upstream of the masked DOM AND gadget. It holds RMAX = D+D*(D-1)/2 independent xorshift32 lanes and presents one fresh N-bit guard word per lane on its `rng` array. It advances every lane once per consumed operation. It owns seeding through a valid/ready handshake and a fixed warm-up, and it flags when its output is fit for use.

---
 rtl/sme_rng_feeder.sv | 118 +++++++++++
 tb/tb_sme_rng_feeder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_rng_feeder.sv
// Randomness feeder for the masked DOM AND gadget: RMAX xorshift32 lanes, seeded
// through a valid/ready handshake and warmed for WARMUP iterations before use.
module sme_rng_feeder #(
  parameter  int D      = 3,
  parameter  int N      = 32,
  parameter  int WARMUP = 8,
  localparam int RMAX   = D + D * (D - 1) / 2,
  localparam int RM     = RMAX - 1
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  output logic         g_clk_req,
  input  logic         seed_valid,
  output logic         seed_ready,
  input  logic [31:0]  seed,
  input  logic         step,
  output logic         rng_valid,
  output logic [N-1:0] rng [RM:0]
);

  typedef enum logic [1:0] {
    ST_UNSEEDED,
    ST_WARM,
    ST_READY
  } state_t;

  localparam logic [31:0] GOLDEN = 32'h9E3779B9;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_seed_ready;
  logic        r_rng_valid;
  logic [31:0] r_lane [RMAX];

  logic [31:0] w_load [RMAX];
  logic [31:0] w_next [RMAX];
  logic        w_accept;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Zero is a fixed point of xorshift, so a lane that would load 0 takes 1.
  always_comb begin
    for (int i = 0; i < RMAX; i++) begin
      w_load[i] = seed ^ (32'(i) * GOLDEN);
      if (w_load[i] == 32'h0) w_load[i] = 32'h1;
      w_next[i] = xs(r_lane[i]);
    end
  end

  assign w_accept = seed_valid & r_seed_ready;

  // NOTE: every sequential assignment below is non-blocking so all lanes and
  // the state advance together from the values present before the edge.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_state      <= ST_UNSEEDED;
      r_cnt        <= 8'd0;
      r_seed_ready <= 1'b1;
      r_rng_valid  <= 1'b0;
      // NOTE: the lane registers are reset explicitly, since the consumer must
      // see all-zero words while unseeded; this is not a RAM, so it costs nothing.
      for (int i = 0; i < RMAX; i++) r_lane[i] <= 32'h0;
    end else begin
      unique case (r_state)
        ST_UNSEEDED: begin
          if (w_accept) begin
            for (int i = 0; i < RMAX; i++) r_lane[i] <= w_load[i];
            r_state      <= ST_WARM;
            r_cnt        <= 8'd0;
            r_seed_ready <= 1'b0;
            r_rng_valid  <= 1'b0;
          end
        end
        ST_WARM: begin
          for (int i = 0; i < RMAX; i++) r_lane[i] <= w_next[i];
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == 8'(WARMUP - 1)) begin
            r_state      <= ST_READY;
            r_seed_ready <= 1'b1;
            r_rng_valid  <= 1'b1;
          end
        end
        ST_READY: begin
          // A reseed takes priority over a step offered in the same cycle.
          if (w_accept) begin
            for (int i = 0; i < RMAX; i++) r_lane[i] <= w_load[i];
            r_state      <= ST_WARM;
            r_cnt        <= 8'd0;
            r_seed_ready <= 1'b0;
            r_rng_valid  <= 1'b0;
          end else if (step) begin
            for (int i = 0; i < RMAX; i++) r_lane[i] <= w_next[i];
          end
        end
        default: begin
          r_state      <= ST_UNSEEDED;
          r_seed_ready <= 1'b1;
          r_rng_valid  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < RMAX; i++) rng[i] = r_lane[i][N-1:0];
  end

  assign seed_ready = r_seed_ready;
  assign rng_valid  = r_rng_valid;
  assign g_clk_req  = seed_valid | (r_state == ST_WARM) | step;

endmodule

// File: tb/tb_sme_rng_feeder.sv
// Scoreboard bench for sme_rng_feeder: two instances (WARMUP=1 and WARMUP=8)
// share the stimulus; a cycle model pushes expectations, a monitor pops them.
module tb_sme_rng_feeder;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        seed_valid;
  logic [31:0] seed;
  logic        step;

  logic        clk_req_a, clk_req_b;
  logic        seed_ready_a, seed_ready_b;
  logic        rng_valid_a, rng_valid_b;
  logic [31:0] rng_a [5:0];
  logic [31:0] rng_b [5:0];

  always #5 g_clk = ~g_clk;

  sme_rng_feeder #(.D(3), .N(32), .WARMUP(1)) u_dut_w1 (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .g_clk_req  (clk_req_a),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready_a),
    .seed       (seed),
    .step       (step),
    .rng_valid  (rng_valid_a),
    .rng        (rng_a)
  );

  sme_rng_feeder #(.D(3), .N(32), .WARMUP(8)) u_dut_w8 (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .g_clk_req  (clk_req_b),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready_b),
    .seed       (seed),
    .step       (step),
    .rng_valid  (rng_valid_b),
    .rng        (rng_b)
  );

  typedef struct packed {
    logic [1:0]             ready;
    logic [1:0]             valid;
    logic [1:0]             clkreq;
    logic [1:0][5:0][31:0]  lane;
    logic                   hand_en;
    logic [2:0]             hand_idx;
    logic [31:0]            hand_val;
  } exp_t;

  typedef enum int {M_UNS, M_WARM, M_READY} mstate_e;

  exp_t        exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        mon_en  = 1'b0;

  mstate_e     m_st  [2];
  int          m_cnt [2];
  logic [31:0] m_lane [2][6];
  int          wu [2] = '{1, 8};

  logic        hand_en  = 1'b0;
  logic [2:0]  hand_idx = 3'd0;
  logic [31:0] hand_val = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [31:0] seed_lane(input logic [31:0] sd, input int i);
    logic [31:0] v;
    v = sd ^ (32'(i) * 32'h9E3779B9);
    return (v == 32'h0) ? 32'h1 : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k]  = M_UNS;
      m_cnt[k] = 0;
      for (int i = 0; i < 6; i++) m_lane[k][i] = 32'h0;
    end
  endtask

  task automatic hand(input int idx, input logic [31:0] val);
    hand_en  = 1'b1;
    hand_idx = 3'(idx);
    hand_val = val;
  endtask

  // One cycle: drive inputs for the coming edge, record what the DUTs show now,
  // then advance the model to the state after that edge.
  task automatic tick(input logic sv, input logic [31:0] sd, input logic st, input logic rn);
    exp_t e;
    @(posedge g_clk);
    #1;
    seed_valid = sv;
    seed       = sd;
    step       = st;
    g_resetn   = rn;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      e.ready[k]  = (m_st[k] != M_WARM);
      e.valid[k]  = (m_st[k] == M_READY);
      e.clkreq[k] = sv | (m_st[k] == M_WARM) | st;
      for (int i = 0; i < 6; i++) e.lane[k][i] = m_lane[k][i];
    end
    e.hand_en  = hand_en;
    e.hand_idx = hand_idx;
    e.hand_val = hand_val;
    hand_en    = 1'b0;
    exp_q.push_back(e);
    mon_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (!rn) begin
        m_st[k]  = M_UNS;
        m_cnt[k] = 0;
        for (int i = 0; i < 6; i++) m_lane[k][i] = 32'h0;
      end else begin
        case (m_st[k])
          M_UNS: if (sv) begin
            for (int i = 0; i < 6; i++) m_lane[k][i] = seed_lane(sd, i);
            m_st[k]  = M_WARM;
            m_cnt[k] = 0;
          end
          M_WARM: begin
            for (int i = 0; i < 6; i++) m_lane[k][i] = xs(m_lane[k][i]);
            if (m_cnt[k] == wu[k] - 1) m_st[k] = M_READY;
            m_cnt[k]++;
          end
          default: begin
            if (sv) begin
              for (int i = 0; i < 6; i++) m_lane[k][i] = seed_lane(sd, i);
              m_st[k]  = M_WARM;
              m_cnt[k] = 0;
            end else if (st) begin
              for (int i = 0; i < 6; i++) m_lane[k][i] = xs(m_lane[k][i]);
            end
          end
        endcase
      end
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle on the falling edge.
  initial begin
    exp_t        e;
    logic [31:0] act;
    logic        dist_ok;
    forever begin
      @(negedge g_clk);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("seed_ready_w1", 32'(seed_ready_a), 32'(e.ready[0]));
          check("seed_ready_w8", 32'(seed_ready_b), 32'(e.ready[1]));
          check("rng_valid_w1",  32'(rng_valid_a),  32'(e.valid[0]));
          check("rng_valid_w8",  32'(rng_valid_b),  32'(e.valid[1]));
          check("clk_req_w1",    32'(clk_req_a),    32'(e.clkreq[0]));
          check("clk_req_w8",    32'(clk_req_b),    32'(e.clkreq[1]));
          for (int i = 0; i < 6; i++) begin
            check($sformatf("rng_w1[%0d]", i), rng_a[i], e.lane[0][i]);
            check($sformatf("rng_w8[%0d]", i), rng_b[i], e.lane[1][i]);
          end
          if (e.hand_en) begin
            act = rng_a[e.hand_idx];
            check($sformatf("hand_rng_w1[%0d]", e.hand_idx), act, e.hand_val);
          end
          for (int k = 0; k < 2; k++) begin
            if (e.valid[k]) begin
              dist_ok = 1'b1;
              for (int i = 0; i < 6; i++)
                for (int j = i + 1; j < 6; j++)
                  if ((k == 0 ? rng_a[i] : rng_b[i]) == (k == 0 ? rng_a[j] : rng_b[j]))
                    dist_ok = 1'b0;
              check($sformatf("distinct_w%0d", wu[k]), 32'(dist_ok), 32'd1);
            end
          end
        end
      end
    end
  end

  initial begin
    g_resetn   = 1'b0;
    seed_valid = 1'b0;
    seed       = 32'h0;
    step       = 1'b0;
    model_reset();
    repeat (3) @(posedge g_clk);

    // Reset state; a step while unseeded must not move the lanes.
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b1);

    // Seed 1: loaded next cycle, valid (WARMUP=1) one cycle later, then 3 steps.
    tick(1'b1, 32'h1, 1'b0, 1'b1);
    hand(0, 32'h00000001);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    hand(0, 32'h00042021);
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    hand(0, 32'h04080601);
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    // The WARMUP=8 instance is still warming: this offer must be ignored by it.
    tick(1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    repeat (8) tick(1'b0, 32'h0, 1'b0, 1'b1);

    // Reseed and step together: reseed wins; lane 1 loads 0 and is forced to 1.
    tick(1'b1, 32'h9E3779B9, 1'b1, 1'b1);
    hand(1, 32'h00000001);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    hand(1, 32'h00042021);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (8) tick(1'b0, 32'h0, 1'b1, 1'b1);

    // Reset in the middle of warm-up, then a full 8-cycle warm-up again.
    tick(1'b1, 32'h12345678, 1'b0, 1'b1);
    repeat (3) tick(1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    tick(1'b1, 32'h0BADF00D, 1'b0, 1'b1);
    repeat (10) tick(1'b0, 32'h0, 1'b0, 1'b1);

    // Random step traffic with periodic nonzero reseeds.
    for (int n = 0; n < 400; n++) begin
      tick((n % 60) == 30, $urandom | 32'h1, 1'($urandom_range(0, 1)), 1'b1);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b1);

    @(negedge g_clk);
    #1;
    mon_en = 1'b0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
